// File: rtl/flit_sink.sv
// flit_sink: FIFO read-side depacketizer enforcing HEADER->PAYLOAD*->TAIL order, odd parity and length.
// Header body (flit bits [28:1]) is {len[11:0], dst[3:0], src[3:0], id[7:0]}.
module flit_sink #(
  parameter int DATA_WIDTH = 32,
  parameter bit CHK_PARITY = 1'b1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  rd_en,
  output logic                  hdr_valid,
  output logic [11:0]           hdr_len,
  output logic [3:0]            hdr_dst,
  output logic [3:0]            hdr_src,
  output logic [7:0]            hdr_id,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-5:0] out_data,
  output logic                  out_last,
  output logic                  pkt_done,
  output logic                  pkt_ok,
  output logic [2:0]            err_flags,
  output logic [CNT_WIDTH-1:0]  pkt_count
);
  localparam logic [2:0] T_HEADER  = 3'b001;
  localparam logic [2:0] T_PAYLOAD = 3'b010;
  localparam logic [2:0] T_TAIL    = 3'b100;
  localparam int E_LEN = 2;
  localparam int E_PAR = 1;
  localparam int E_SEQ = 0;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  typedef enum logic [1:0] {S_IDLE, S_BODY, S_DROP} state_t;

  state_t                r_state, w_state_nxt;
  logic [11:0]           r_cnt, w_cnt_nxt, w_cnt_inc;
  logic                  r_bad, w_bad_nxt;
  logic [2:0]            r_err, w_err_nxt;
  logic [11:0]           r_hdr_len, w_hdr_len_nxt;
  logic [3:0]            r_hdr_dst, w_hdr_dst_nxt;
  logic [3:0]            r_hdr_src, w_hdr_src_nxt;
  logic [7:0]            r_hdr_id, w_hdr_id_nxt;
  logic                  r_hdr_valid, w_hdr_valid_nxt;
  logic                  r_out_valid, w_out_valid_nxt;
  logic [DATA_WIDTH-5:0] r_out_data, w_out_data_nxt;
  logic                  r_out_last, w_out_last_nxt;
  logic                  r_done, w_done_nxt;
  logic                  r_ok, w_ok_nxt;
  logic [CNT_WIDTH-1:0]  r_pkt_count;

  logic [2:0]            w_type;
  logic [DATA_WIDTH-5:0] w_body;
  logic                  w_par_ok;
  logic                  w_pop;
  logic                  w_len_hit;
  logic                  w_take_hdr;

  assign w_type    = data_in[DATA_WIDTH-1 -: 3];
  assign w_body    = data_in[DATA_WIDTH-4:1];
  assign w_par_ok  = !CHK_PARITY || (^data_in);
  // Gated by rst so the pop request also drops the instant reset asserts.
  assign w_pop     = rst & ~empty & (~r_out_valid | out_ready);
  assign w_cnt_inc = (r_cnt == 12'hFFF) ? r_cnt : r_cnt + 12'd1;
  assign w_len_hit = (w_cnt_inc == r_hdr_len);

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_bad_nxt       = r_bad;
    w_err_nxt       = r_err;
    w_hdr_len_nxt   = r_hdr_len;
    w_hdr_dst_nxt   = r_hdr_dst;
    w_hdr_src_nxt   = r_hdr_src;
    w_hdr_id_nxt    = r_hdr_id;
    w_hdr_valid_nxt = 1'b0;
    w_done_nxt      = 1'b0;
    w_ok_nxt        = 1'b0;
    w_out_valid_nxt = r_out_valid & ~out_ready;
    w_out_data_nxt  = r_out_data;
    w_out_last_nxt  = r_out_last;
    w_take_hdr      = 1'b0;

    if (w_pop) begin
      case (r_state)
        S_IDLE: begin
          if (w_type == T_HEADER) w_take_hdr = 1'b1;
          else                    w_err_nxt[E_SEQ] = 1'b1;
        end
        S_BODY: begin
          if (!w_par_ok) begin
            w_err_nxt[E_PAR] = 1'b1;
            w_bad_nxt        = 1'b1;
          end
          case (w_type)
            T_PAYLOAD: begin
              w_cnt_nxt       = w_cnt_inc;
              w_out_valid_nxt = 1'b1;
              w_out_data_nxt  = w_body;
              w_out_last_nxt  = 1'b0;
              if (w_len_hit) begin
                w_err_nxt[E_LEN] = 1'b1;
                w_bad_nxt        = 1'b1;
              end
            end
            T_TAIL: begin
              w_cnt_nxt       = w_cnt_inc;
              w_out_valid_nxt = 1'b1;
              w_out_data_nxt  = w_body;
              w_out_last_nxt  = 1'b1;
              if (!w_len_hit) w_err_nxt[E_LEN] = 1'b1;
              w_done_nxt      = 1'b1;
              w_ok_nxt        = w_len_hit & ~r_bad & w_par_ok;
              w_state_nxt     = S_IDLE;
            end
            T_HEADER: begin
              // Unterminated packet is closed as bad, then the new header starts fresh.
              w_err_nxt[E_SEQ] = 1'b1;
              w_done_nxt       = 1'b1;
              w_take_hdr       = 1'b1;
            end
            default: begin
              w_err_nxt[E_SEQ] = 1'b1;
              w_bad_nxt        = 1'b1;
            end
          endcase
        end
        S_DROP: begin
          if (w_type == T_TAIL) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end else if (w_type == T_HEADER) begin
            w_err_nxt[E_SEQ] = 1'b1;
            w_take_hdr       = 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase

      if (w_take_hdr) begin
        if (w_par_ok) begin
          w_hdr_len_nxt   = w_body[27:16];
          w_hdr_dst_nxt   = w_body[15:12];
          w_hdr_src_nxt   = w_body[11:8];
          w_hdr_id_nxt    = w_body[7:0];
          w_hdr_valid_nxt = 1'b1;
          w_cnt_nxt       = 12'd1;
          w_bad_nxt       = (w_body[27:16] < 12'd2);
          if (w_body[27:16] < 12'd2) w_err_nxt[E_LEN] = 1'b1;
          w_state_nxt     = S_BODY;
        end else begin
          w_err_nxt[E_PAR] = 1'b1;
          w_state_nxt      = S_DROP;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bad       <= 1'b0;
      r_err       <= '0;
      r_hdr_len   <= '0;
      r_hdr_dst   <= '0;
      r_hdr_src   <= '0;
      r_hdr_id    <= '0;
      r_hdr_valid <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
      r_ok        <= 1'b0;
      r_pkt_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bad       <= w_bad_nxt;
      r_err       <= w_err_nxt;
      r_hdr_len   <= w_hdr_len_nxt;
      r_hdr_dst   <= w_hdr_dst_nxt;
      r_hdr_src   <= w_hdr_src_nxt;
      r_hdr_id    <= w_hdr_id_nxt;
      r_hdr_valid <= w_hdr_valid_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_last  <= w_out_last_nxt;
      r_done      <= w_done_nxt;
      r_ok        <= w_ok_nxt;
      if (w_done_nxt && w_ok_nxt) r_pkt_count <= r_pkt_count + CNT_ONE;
    end
  end

  assign rd_en     = w_pop;
  assign hdr_valid = r_hdr_valid;
  assign hdr_len   = r_hdr_len;
  assign hdr_dst   = r_hdr_dst;
  assign hdr_src   = r_hdr_src;
  assign hdr_id    = r_hdr_id;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign pkt_done  = r_done;
  assign pkt_ok    = r_ok;
  assign err_flags = r_err;
  assign pkt_count = r_pkt_count;
endmodule

// File: tb/tb_flit_sink.sv
// Directed bench for flit_sink: a queue-backed show-ahead FIFO feeds two instances
// (parity checked / parity ignored); monitors collect words and packet pulses.
module tb_flit_sink;
  localparam logic [2:0] H = 3'b001;
  localparam logic [2:0] P = 3'b010;
  localparam logic [2:0] T = 3'b100;

  logic        clk = 1'b0;
  logic        rst;
  logic        empty, empty2;
  logic [31:0] data_in, data_in2;
  logic        out_ready, out_ready2;
  logic        rd_en, hdr_valid, out_valid, out_last, pkt_done, pkt_ok;
  logic [11:0] hdr_len;
  logic [3:0]  hdr_dst, hdr_src;
  logic [7:0]  hdr_id;
  logic [27:0] out_data;
  logic [2:0]  err_flags;
  logic [15:0] pkt_count;
  logic        rd_en2, hdr_valid2, out_valid2, out_last2, pkt_done2, pkt_ok2;
  logic [11:0] hdr_len2;
  logic [3:0]  hdr_dst2, hdr_src2;
  logic [7:0]  hdr_id2;
  logic [27:0] out_data2;
  logic [2:0]  err_flags2;
  logic [15:0] pkt_count2;

  logic [31:0] q[$];
  logic [31:0] q2[$];
  logic [27:0] rx_data[$];
  logic        rx_last[$];
  int n_checks = 0, n_errors = 0;
  int n_hdr, n_ov, n_done, n_ok, bad_pop;
  int n2_hdr, n2_words, n2_ok;

  always #5 clk = ~clk;

  flit_sink #(.DATA_WIDTH(32), .CHK_PARITY(1'b1), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .empty(empty), .data_in(data_in), .rd_en(rd_en),
    .hdr_valid(hdr_valid), .hdr_len(hdr_len), .hdr_dst(hdr_dst), .hdr_src(hdr_src),
    .hdr_id(hdr_id), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .pkt_done(pkt_done), .pkt_ok(pkt_ok), .err_flags(err_flags),
    .pkt_count(pkt_count)
  );

  flit_sink #(.DATA_WIDTH(32), .CHK_PARITY(1'b0), .CNT_WIDTH(16)) dut_np (
    .clk(clk), .rst(rst), .empty(empty2), .data_in(data_in2), .rd_en(rd_en2),
    .hdr_valid(hdr_valid2), .hdr_len(hdr_len2), .hdr_dst(hdr_dst2), .hdr_src(hdr_src2),
    .hdr_id(hdr_id2), .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
    .out_last(out_last2), .pkt_done(pkt_done2), .pkt_ok(pkt_ok2), .err_flags(err_flags2),
    .pkt_count(pkt_count2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Odd parity over the whole flit; bad_par flips the parity bit.
  function automatic logic [31:0] mk(input logic [2:0] ty, input logic [27:0] body, input bit bad_par);
    logic p;
    p = ~(^{ty, body});
    return {ty, body, p ^ bad_par};
  endfunction

  function automatic logic [27:0] hb(input logic [11:0] len, input logic [3:0] d,
                                     input logic [3:0] s, input logic [7:0] id);
    return {len, d, s, id};
  endfunction

  function automatic logic [27:0] pw(input int i);
    return 28'h5A5A001 + 28'(i);
  endfunction

  task automatic drive_fifo();
    empty    = (q.size() == 0);
    data_in  = empty ? 32'h0 : q[0];
    empty2   = (q2.size() == 0);
    data_in2 = empty2 ? 32'h0 : q2[0];
  endtask

  task automatic push(input logic [31:0] f);
    q.push_back(f);
    drive_fifo();
  endtask

  task automatic push2(input logic [31:0] f);
    q2.push_back(f);
    drive_fifo();
  endtask

  task automatic clear_mon();
    rx_data.delete();
    rx_last.delete();
    n_hdr = 0; n_ov = 0; n_done = 0; n_ok = 0; bad_pop = 0;
    n2_hdr = 0; n2_words = 0; n2_ok = 0;
  endtask

  // One clock: sample pop/handshake mid-cycle, then pop the model FIFO and record pulses after the edge.
  task automatic tick();
    logic pop1, pop2;
    #1;
    pop1 = rd_en;
    pop2 = rd_en2;
    if (rd_en && (empty || (out_valid && !out_ready))) bad_pop++;
    if (out_valid && out_ready) begin
      rx_data.push_back(out_data);
      rx_last.push_back(out_last);
    end
    if (out_valid2 && out_ready2) n2_words++;
    @(posedge clk);
    #1;
    if (pop1) q.delete(0);
    if (pop2) q2.delete(0);
    drive_fifo();
    if (hdr_valid) n_hdr++;
    if (out_valid) n_ov++;
    if (pkt_done) begin
      n_done++;
      if (pkt_ok) n_ok++;
    end
    if (hdr_valid2) n2_hdr++;
    if (pkt_done2 && pkt_ok2) n2_ok++;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    q.delete();
    q2.delete();
    drive_fifo();
    out_ready = 1'b1;
    run(2);
    rst = 1'b1;
    tick();
    clear_mon();
  endtask

  task automatic push_std();
    push(mk(H, hb(12'd5, 4'd9, 4'd3, 8'd1), 1'b0));
    for (int i = 0; i < 3; i++) push(mk(P, pw(i), 1'b0));
    push(mk(T, pw(3), 1'b0));
  endtask

  task automatic push_good();
    push(mk(H, hb(12'd3, 4'd1, 4'd2, 8'd7), 1'b0));
    push(mk(P, pw(0), 1'b0));
    push(mk(T, pw(1), 1'b0));
  endtask

  task automatic check_words(input string tag);
    check({tag, "_nwords"}, rx_data.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_w%0d", tag, i),
            (i < rx_data.size()) ? {4'h0, rx_data[i]} : 32'hxxxxxxxx, {4'h0, pw(i)});
      check($sformatf("%s_last%0d", tag, i),
            (i < rx_last.size()) ? {31'h0, rx_last[i]} : 32'hxxxxxxxx, (i == 3) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    rst = 1'b0;
    out_ready  = 1'b1;
    out_ready2 = 1'b1;
    clear_mon();
    drive_fifo();
    run(2);
    check("rst_ctl", {rd_en, hdr_valid, out_valid, out_last, pkt_done, pkt_ok, err_flags}, 0);
    check("rst_hdr", {hdr_len, hdr_dst, hdr_src, hdr_id}, 0);
    check("rst_data", out_data, 0);
    check("rst_count", pkt_count, 0);
    rst = 1'b1;
    tick();
    clear_mon();

    // T1: well-formed packet, sink always ready
    push_std();
    run(10);
    check("t1_hdr_valid_cnt", n_hdr, 1);
    check("t1_hdr_fields", {hdr_len, hdr_dst, hdr_src, hdr_id}, {12'd5, 4'd9, 4'd3, 8'd1});
    check_words("t1");
    check("t1_done", n_done, 1);
    check("t1_ok", n_ok, 1);
    check("t1_count", pkt_count, 1);
    check("t1_err", err_flags, 3'b000);
    check("t1_rd_rule", bad_pop, 0);

    // T2: same packet, 6-cycle downstream stall after the first word
    clear_mon();
    push_std();
    for (int k = 0; k < 10 && !out_valid; k++) tick();
    check("t2_first_word_seen", out_valid, 1);
    out_ready = 1'b0;
    run(6);
    check("t2_stall_fifo_kept", q.size(), 3);
    check("t2_stall_rd_en", rd_en, 0);
    check("t2_stall_no_pop", bad_pop, 0);
    check("t2_stall_held", {out_valid, out_data}, {1'b1, 28'h5A5A001});
    out_ready = 1'b1;
    run(8);
    check_words("t2");
    check("t2_count", pkt_count, 2);

    // T3: short packet, then good packet; length boundaries
    do_reset();
    push(mk(H, hb(12'd5, 4'd9, 4'd3, 8'd1), 1'b0));
    push(mk(P, pw(0), 1'b0));
    push(mk(T, pw(1), 1'b0));
    run(6);
    check("t3_done", n_done, 1);
    check("t3_not_ok", n_ok, 0);
    check("t3_err", err_flags, 3'b100);
    push_good();
    run(6);
    check("t3_good_ok", n_ok, 1);
    check("t3_good_count", pkt_count, 1);
    do_reset();
    push(mk(H, hb(12'd2, 4'd1, 4'd1, 8'd3), 1'b0));
    push(mk(P, pw(0), 1'b0));
    run(4);
    check("t3_payload_at_len", err_flags, 3'b100);
    check("t3_payload_no_done", n_done, 0);
    do_reset();
    push(mk(H, hb(12'd1, 4'd1, 4'd1, 8'd4), 1'b0));
    run(3);
    check("t3_hdr_len_lt2", err_flags, 3'b100);
    push(mk(T, pw(0), 1'b0));
    run(3);
    check("t3_len1_done", {n_done[7:0], n_ok[7:0]}, {8'd1, 8'd0});

    // T4: stray payload, then header inside a packet
    do_reset();
    push(mk(P, pw(0), 1'b0));
    run(4);
    check("t4_seq_err", err_flags, 3'b001);
    check("t4_no_out_valid", n_ov, 0);
    check("t4_discarded", q.size(), 0);
    push(mk(H, hb(12'd5, 4'd9, 4'd3, 8'd1), 1'b0));
    push(mk(P, pw(0), 1'b0));
    push(mk(H, hb(12'd3, 4'd4, 4'd7, 8'd2), 1'b0));
    push(mk(P, pw(1), 1'b0));
    push(mk(T, pw(2), 1'b0));
    run(10);
    check("t4_done", n_done, 2);
    check("t4_ok", n_ok, 1);
    check("t4_hdr_cnt", n_hdr, 2);
    check("t4_hdr2_fields", {hdr_len, hdr_dst, hdr_src, hdr_id}, {12'd3, 4'd4, 4'd7, 8'd2});
    check("t4_words", rx_data.size(), 3);
    check("t4_count", pkt_count, 1);
    check("t4_err", err_flags, 3'b001);

    // T5: bad-parity header dropped; ignored when parity checking is off
    do_reset();
    push(mk(H, hb(12'd3, 4'd1, 4'd2, 8'd7), 1'b1));
    push(mk(P, pw(0), 1'b0));
    push(mk(T, pw(1), 1'b0));
    run(8);
    check("t5_par_err", err_flags, 3'b010);
    check("t5_no_out_valid", n_ov, 0);
    check("t5_no_hdr", n_hdr, 0);
    check("t5_done_bad", {n_done[7:0], n_ok[7:0]}, {8'd1, 8'd0});
    push2(mk(H, hb(12'd3, 4'd1, 4'd2, 8'd7), 1'b1));
    push2(mk(P, pw(0), 1'b0));
    push2(mk(T, pw(1), 1'b0));
    run(8);
    check("t5np_hdr", n2_hdr, 1);
    check("t5np_words", n2_words, 2);
    check("t5np_ok", n2_ok, 1);
    check("t5np_count", pkt_count2, 1);
    check("t5np_err", err_flags2, 3'b000);

    // T6: asynchronous reset mid-body
    do_reset();
    push_good();
    run(6);
    check("t6_pre_count", pkt_count, 1);
    push(mk(H, hb(12'd5, 4'd9, 4'd3, 8'd1), 1'b0));
    for (int i = 0; i < 3; i++) push(mk(P, pw(i), 1'b0));
    run(3);
    check("t6_mid_body", out_valid, 1);
    #3;
    rst = 1'b0;
    #1;
    check("t6_async_ctl", {rd_en, hdr_valid, out_valid, out_last, pkt_done, pkt_ok, err_flags}, 0);
    check("t6_async_hdr", {hdr_len, hdr_dst, hdr_src, hdr_id}, 0);
    check("t6_async_data", out_data, 0);
    check("t6_async_count", pkt_count, 0);
    q.delete();
    drive_fifo();
    run(2);
    check("t6_no_done_on_reset", n_done, 1);
    rst = 1'b1;
    tick();
    push_good();
    run(6);
    check("t6_after_count", pkt_count, 1);
    check("t6_after_ok", n_ok, 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
